fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning instruction-memory word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning instruction and PC width.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning prefetch buffer entries (power of 2, >=2).
REQ-004 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch byte address.
REQ-005 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 The block SHALL have port imem_en  output  1  read request to synchronous instruction memory.
REQ-008 The block SHALL have port imem_addr  output  ADDR_WIDTH  word address, equal to fetch_pc[ADDR_WIDTH+1:2].
REQ-009 The block SHALL have port imem_rdata  input  DATA_WIDTH  read data, valid the cycle after imem_en.
REQ-010 The block SHALL have port instr  output  DATA_WIDTH  instruction at buffer head.
REQ-011 The block SHALL have port instr_pc  output  DATA_WIDTH  byte PC of instr.
REQ-012 The block SHALL have port instr_valid  output  1  buffer head holds a valid instruction.
REQ-013 The block SHALL have port instr_ready  input  1  decode stage accepts instr this cycle.
REQ-014 The block SHALL have port redirect  input  1  taken branch/jump, flush and refetch.
REQ-015 The block SHALL have port redirect_pc  input  DATA_WIDTH  byte target of redirect.

Function
REQ-016 Internal state SHALL be: fetch_pc, one in-flight flag with its PC, DEPTH-entry FIFO of {instr, pc}, occupancy count (0..DEPTH).
REQ-017 pop SHALL equal instr_valid AND instr_ready AND NOT redirect.
REQ-018 imem_en SHALL be 1 iff NOT redirect AND (count + inflight - pop) < DEPTH; combinational from instr_ready allowed.
REQ-019 On an issued request, fetch_pc SHALL advance by 4 (mod 2^32, wrap-around silent); in-flight flag SHALL set with the issued PC.
REQ-020 In the cycle after a request, imem_rdata and its PC SHALL be written into the FIFO tail at the clock edge and in-flight SHALL clear unless a new request issues.
REQ-021 instr_valid SHALL equal (count != 0); instr/instr_pc SHALL be the FIFO head, registered (no bypass of imem_rdata).
REQ-022 Simultaneous push and pop SHALL keep count unchanged; push while full SHALL be impossible by construction (REQ-018) and asserted in verification.
REQ-023 instr/instr_pc SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-024 redirect SHALL take priority over push, pop and issue: at the edge count<=0, in-flight data discarded, fetch_pc<=redirect_pc with bits [1:0] forced to 0.
REQ-025 The cycle after redirect SHALL issue a request at redirect_pc if buffer empty; redirect on consecutive cycles SHALL use the latest target.
REQ-026 Latency: request in cycle N -> instr_valid=1 in cycle N+2; steady state with instr_ready=1 SHALL sustain one instruction per cycle.
REQ-027 Order SHALL be strictly program order; no instruction delivered twice or skipped except via redirect.

Reset
REQ-028 While rst=0: fetch_pc=RESET_PC, count=0, in-flight=0, instr_valid=0, instr=0, instr_pc=0, imem_en=0.
REQ-029 Reset asserted mid-operation SHALL take effect immediately (asynchronous), discarding buffer and in-flight data.
REQ-030 First cycle after rst deasserts SHALL issue imem_en=1, imem_addr=RESET_PC[ADDR_WIDTH+1:2].

Verification
REQ-031 Reset release, instr_ready=1, memory word k = 32'h1000_0000+k -> instr_valid rises cycle 2; instr_pc 0,4,8,... instr 1000_0000,1000_0001,... one per cycle.
REQ-032 instr_ready=0 for 10 cycles after first valid -> exactly DEPTH entries buffered, imem_en=0, instr stable at PC 0; release -> PCs 0,4,8 contiguous, no loss.
REQ-033 redirect=1, redirect_pc=32'h0000_0043 while buffer full and request in flight -> instr_valid=0 next cycle, next imem_addr=8'h10, next delivered instr_pc=32'h0000_0040.
REQ-034 Redirect and instr_ready=1 in same cycle -> no pop counted, head discarded, old in-flight data never appears at instr.
REQ-035 RESET_PC=32'hFFFF_FFFC, ADDR_WIDTH=8 -> instr_pc FFFF_FFFC then 0000_0000; imem_addr 8'hFF then 8'h00.
REQ-036 rst pulsed low mid-stream (asynchronous, between edges) -> instr_valid=0 immediately; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction prefetch unit with a small in-order buffer and redirect flush
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf_instr [DEPTH];
  logic [DATA_WIDTH-1:0] buf_pc    [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic                  pop;
  logic [CW:0]           occupancy;

  assign instr_valid = (count != '0);
  assign instr       = buf_instr[rd_ptr];
  assign instr_pc    = buf_pc[rd_ptr];
  assign pop         = instr_valid && instr_ready && !redirect;

  // Counting the in-flight word as occupied guarantees its slot exists when it lands.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign imem_en   = rst && !redirect && (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc[ADDR_WIDTH+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~DATA_WIDTH'(3);
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (inflight) begin
        buf_instr[wr_ptr] <= imem_rdata;
        buf_pc[wr_ptr]    <= inflight_pc;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count    <= count + CW'(inflight) - CW'(pop);
      inflight <= imem_en;
      if (imem_en) begin
        fetch_pc    <= fetch_pc + DATA_WIDTH'(4);
        inflight_pc <= fetch_pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit against a program-order reference
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC_MAIN = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en, instr_valid, instr_ready, redirect;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata, instr, instr_pc, redirect_pc;

  logic        en2, valid2;
  logic [7:0]  addr2;
  logic [31:0] rdata2, instr2, pc2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] gen_pc;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC_MAIN)) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(2), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .imem_en(en2), .imem_addr(addr2), .imem_rdata(rdata2),
    .instr(instr2), .instr_pc(pc2), .instr_valid(valid2), .instr_ready(1'b1),
    .redirect(1'b0), .redirect_pc(32'h0)
  );

  // Memory word k holds 0x1000_0000 + k; idle cycles return junk to expose any bypass.
  always @(posedge clk) begin
    imem_rdata <= imem_en ? 32'h1000_0000 + {24'h0, imem_addr} : $urandom;
    rdata2     <= en2 ? 32'h1000_0000 + {24'h0, addr2} : $urandom;
  end

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h1000_0000 + {24'h0, pc[9:2]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic topup();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc  = gen_pc;
      e.ins = word_at(gen_pc);
      exp_q.push_back(e);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic flush_to(input logic [31:0] pc);
    exp_q.delete();
    gen_pc = pc;
    topup();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    topup();
  endtask

  task automatic start_redirect(input logic [31:0] target, input logic rdy);
    redirect    = 1'b1;
    redirect_pc = target;
    instr_ready = rdy;
    flush_to(target & ~32'd3);
  endtask

  int          occ;
  int          arrives;
  int          pop_i;
  logic        en_prev;
  logic        hold;
  logic [31:0] hold_instr, hold_pc, fpc;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      occ     = 0;
      en_prev = 1'b0;
      hold    = 1'b0;
      fpc     = RESET_PC_MAIN;
    end else begin
      arrives = en_prev ? 1 : 0;
      pop_i   = (instr_valid && instr_ready && !redirect) ? 1 : 0;
      check("valid_vs_occupancy", instr_valid, occ != 0);
      check("imem_en_rule", imem_en, !redirect && ((occ + arrives - pop_i) < DEPTH));
      if (imem_en) check("imem_addr", imem_addr, fpc[9:2]);
      if (hold) begin
        check("hold_valid", instr_valid, 1'b1);
        check("hold_instr", instr, hold_instr);
        check("hold_pc", instr_pc, hold_pc);
      end
      if (pop_i != 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty actual_pc=%0h required=none", instr_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("deliver_pc", instr_pc, mon_e.pc);
          check("deliver_instr", instr, mon_e.ins);
        end
      end
      hold       = instr_valid && !instr_ready && !redirect;
      hold_instr = instr;
      hold_pc    = instr_pc;
      if (redirect) begin
        occ = 0;
        fpc = redirect_pc & ~32'd3;
      end else begin
        occ = occ + arrives - pop_i;
        if (imem_en) fpc = fpc + 32'd4;
      end
      en_prev = imem_en;
    end
  end

  initial begin
    rst         = 1'b0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    flush_to(RESET_PC_MAIN);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    @(negedge clk);
    check("first_en", imem_en, 1'b1);
    check("first_addr", imem_addr, 8'h00);
    check("wrap_first_en", en2, 1'b1);
    check("wrap_addr_c0", addr2, 8'hFF);
    @(negedge clk);
    check("valid_c1", instr_valid, 1'b0);
    check("wrap_addr_c1", addr2, 8'h00);
    @(negedge clk);
    check("valid_c2", instr_valid, 1'b1);
    check("pc_c2", instr_pc, 32'h0);
    check("instr_c2", instr, 32'h1000_0000);
    check("wrap_pc_c2", pc2, 32'hFFFF_FFFC);
    check("wrap_instr_c2", instr2, 32'h1000_00FF);
    @(negedge clk);
    check("pc_c3", instr_pc, 32'h4);
    check("wrap_pc_c3", pc2, 32'h0);
    check("wrap_instr_c3", instr2, 32'h1000_0000);

    // Stall the decoder from the first valid at PC 0 and let the buffer fill.
    tick();
    start_redirect(32'h0, 1'b0);
    tick();
    redirect = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    check("stall_valid", instr_valid, 1'b1);
    check("stall_pc", instr_pc, 32'h0);
    check("stall_en", imem_en, 1'b0);
    tick();
    instr_ready = 1'b1;
    repeat (6) tick();

    instr_ready = 1'b0;
    repeat (5) tick();
    start_redirect(32'h0000_0043, 1'b1);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("redir_full_valid", instr_valid, 1'b0);
    check("redir_full_en", imem_en, 1'b1);
    check("redir_full_addr", imem_addr, 8'h10);
    repeat (6) tick();

    start_redirect(32'h0000_0083, 1'b1);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("redir_inflight_valid", instr_valid, 1'b0);
    check("redir_inflight_addr", imem_addr, 8'h20);

    tick();
    start_redirect(32'h0000_0100, 1'b1);
    tick();
    start_redirect(32'h0000_0204, 1'b1);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("redir_latest_en", imem_en, 1'b1);
    check("redir_latest_addr", imem_addr, 8'h81);
    repeat (4) tick();

    for (int i = 0; i < 3000; i++) begin
      tick();
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect_pc = $urandom;
      redirect    = ($urandom_range(0, 15) == 0);
      if (redirect) flush_to(redirect_pc & ~32'd3);
    end
    tick();
    redirect    = 1'b0;
    instr_ready = 1'b1;
    repeat (3) tick();

    #2 rst = 1'b0;
    #1;
    check("async_valid", instr_valid, 1'b0);
    check("async_en", imem_en, 1'b0);
    check("async_instr", instr, 32'h0);
    check("async_pc", instr_pc, 32'h0);
    flush_to(RESET_PC_MAIN);
    repeat (2) tick();
    rst = 1'b1;
    @(negedge clk);
    check("restart_en", imem_en, 1'b1);
    check("restart_addr", imem_addr, 8'h00);
    repeat (10) tick();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
